// File: rtl/bus_sched_rr.sv
// bus_sched_rr
//   Round-robin scheduler for a shared broadcast bus. Pops one packet at a
//   time from a pending device FIFO, decodes the 8-bit destination ID in the
//   packet MSBs and pushes it to the destination FIFO, or to every other
//   device on the broadcast ID. Waits on destination backpressure up to
//   max_wait cycles, then drops; invalid IDs are dropped at once.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   pndng     in   per-device FIFO non-empty flags
//   D_pop     in   per-device head packet (show-ahead)
//   full      in   per-device input FIFO full flags
//   pop       out  one-hot pop strobe to the granted source (registered)
//   push      out  push strobes to destination FIFOs (registered)
//   D_push    out  packet to destinations, holds its last pushed value
//   busy      out  high whenever the scheduler is not idle
//   drop_cnt  out  saturating dropped-packet counter
module bus_sched_rr #(
    parameter int unsigned drvrs      = 4,
    parameter int unsigned pckg_sz    = 16,
    parameter logic [7:0]  brdcst_ind = 8'hFF,
    parameter int unsigned max_wait   = 16,
    parameter int unsigned cnt_w      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    input  logic [drvrs-1:0]                full,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              D_push,
    output logic                            busy,
    output logic [cnt_w-1:0]                drop_cnt
);

    localparam int unsigned IW = $clog2(drvrs);
    localparam int unsigned WW = $clog2(max_wait + 1);

    typedef enum logic [1:0] {IDLE, POP, ROUTE} state_t;

    state_t             r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_src;
    logic [pckg_sz-1:0] r_pkt;
    logic [WW-1:0]      r_wait_cnt;
    logic [drvrs-1:0]   r_pop;
    logic [drvrs-1:0]   r_push;
    logic [pckg_sz-1:0] r_d_push;
    logic               r_busy;
    logic [cnt_w-1:0]   r_drop_cnt;

    // Round-robin pick: first pending device at or above r_ptr, wrapping.
    // Scanning offsets from high to low lets the smallest offset win.
    logic [IW:0]        w_idx;
    logic [IW-1:0]      w_sel;
    logic               w_any;

    always_comb begin
        w_sel = r_ptr;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = int'(drvrs) - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(drvrs)) begin
                w_idx = w_idx - (IW+1)'(drvrs);
            end
            if (pndng[w_idx[IW-1:0]]) begin
                w_sel = w_idx[IW-1:0];
                w_any = 1'b1;
            end
        end
    end

    // Destination decode of the captured packet.
    logic [7:0]         w_dst;
    logic               w_is_bcast;
    logic               w_is_ucast;
    logic [drvrs-1:0]   w_src_oh;
    logic [drvrs-1:0]   w_dst_oh;
    logic [drvrs-1:0]   w_tgt;
    logic               w_blocked;
    logic [IW-1:0]      w_ptr_next;
    logic [cnt_w-1:0]   w_drop_inc;

    assign w_dst      = r_pkt[pckg_sz-1 -: 8];
    assign w_is_bcast = (w_dst == brdcst_ind);
    assign w_is_ucast = !w_is_bcast && (w_dst < 8'(drvrs)) && (w_dst != 8'(r_src));
    assign w_src_oh   = {{(drvrs-1){1'b0}}, 1'b1} << r_src;
    assign w_dst_oh   = {{(drvrs-1){1'b0}}, 1'b1} << w_dst[IW-1:0];
    assign w_tgt      = w_is_bcast ? ~w_src_oh : (w_is_ucast ? w_dst_oh : '0);
    // A broadcast goes out only when every target can accept it together.
    assign w_blocked  = |(full & w_tgt);
    assign w_ptr_next = (r_src == IW'(drvrs - 1)) ? '0 : r_src + 1'b1;
    assign w_drop_inc = (r_drop_cnt == '1) ? r_drop_cnt : r_drop_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_src      <= '0;
            r_pkt      <= '0;
            r_wait_cnt <= '0;
            r_pop      <= '0;
            r_push     <= '0;
            r_d_push   <= '0;
            r_busy     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_pop  <= '0;
            r_push <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_src   <= w_sel;
                        r_state <= POP;
                        r_busy  <= 1'b1;
                    end
                end
                POP: begin
                    // The request may have been withdrawn since IDLE sampled it.
                    if (pndng[r_src]) begin
                        r_pop      <= w_src_oh;
                        r_pkt      <= D_pop[r_src];
                        r_ptr      <= w_ptr_next;
                        r_wait_cnt <= '0;
                        r_state    <= ROUTE;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ROUTE: begin
                    if (!(w_is_bcast || w_is_ucast)) begin
                        r_drop_cnt <= w_drop_inc;
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                    end else if (!w_blocked) begin
                        r_push   <= w_tgt;
                        r_d_push <= r_pkt;
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                    end else if (r_wait_cnt == WW'(max_wait)) begin
                        r_drop_cnt <= w_drop_inc;
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pop      = r_pop;
    assign push     = r_push;
    assign D_push   = r_d_push;
    assign busy     = r_busy;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_bus_sched_rr.sv
// tb_bus_sched_rr
//   Self-checking bench for bus_sched_rr (4 devices, 16-bit packets,
//   max_wait 16, 8-bit drop counter). A transaction-level reference thread
//   predicts the registered outputs after every clock edge; a monitor compares
//   them on the falling edge. Directed scenarios add fixed expectations.
module tb_bus_sched_rr;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MW = 16;
    localparam int CW = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [N-1:0]       pndng = '0;
    logic [N-1:0][W-1:0] D_pop = '0;
    logic [N-1:0]       full = '0;
    logic [N-1:0]       pop;
    logic [N-1:0]       push;
    logic [W-1:0]       D_push;
    logic               busy;
    logic [CW-1:0]      drop_cnt;

    always #5 clk = ~clk;

    bus_sched_rr #(
        .drvrs      (N),
        .pckg_sz    (W),
        .brdcst_ind (8'hFF),
        .max_wait   (MW),
        .cnt_w      (CW)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .full     (full),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_pop = '0;
    logic [N-1:0] m_push = '0;
    logic [W-1:0] m_dpush = '0;
    logic         m_busy = 1'b0;
    int           m_drop = 0;
    logic [1:0]   m_ptr = '0;

    task automatic tick(output bit rst);
        @(posedge clk);
        rst = (reset == 1'b0);
        if (rst) begin
            m_pop   = '0;
            m_push  = '0;
            m_dpush = '0;
            m_busy  = 1'b0;
            m_drop  = 0;
            m_ptr   = '0;
        end
    endtask

    initial begin : model
        bit         r;
        bit         found;
        bit         done;
        logic [1:0] src;
        logic [1:0] idx;
        logic [W-1:0] pkt;
        logic [7:0] dst;
        logic [N-1:0] tgt;
        forever begin
            tick(r);
            if (r) continue;
            m_pop  = '0;
            m_push = '0;
            m_busy = 1'b0;
            if (pndng == '0) continue;
            // Grant the first requester at or after the pointer, wrapping.
            found = 1'b0;
            src = '0;
            for (int k = 0; k < N; k++) begin
                idx = m_ptr + 2'(k);
                if (!found && pndng[idx]) begin
                    src = idx;
                    found = 1'b1;
                end
            end
            m_busy = 1'b1;
            tick(r);
            if (r) continue;
            if (!pndng[src]) begin
                m_busy = 1'b0;
                continue;
            end
            m_pop = 4'b0001 << src;
            pkt   = D_pop[src];
            m_ptr = src + 2'd1;
            dst   = pkt[W-1 -: 8];
            if (dst == 8'hFF)                           tgt = ~(4'b0001 << src);
            else if (dst < 8'd4 && dst != {6'b0, src})  tgt = 4'b0001 << dst[1:0];
            else                                        tgt = '0;
            done = 1'b0;
            for (int waited = 0; !done; waited++) begin
                tick(r);
                if (r) break;
                m_pop = '0;
                if (tgt == '0 || ((full & tgt) != '0 && waited == MW)) begin
                    if (m_drop < 255) m_drop++;
                    done = 1'b1;
                end else if ((full & tgt) == '0) begin
                    m_push  = tgt;
                    m_dpush = pkt;
                    done = 1'b1;
                end
                if (done) m_busy = 1'b0;
            end
        end
    end

    // Compare every cycle while out of reset.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                check("pop", 32'(pop), 32'(m_pop));
                check("push", 32'(push), 32'(m_push));
                check("D_push", 32'(D_push), 32'(m_dpush));
                check("busy", 32'(busy), 32'(m_busy));
                check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
                if ((pop & {N{1'b1}}) != '0 && push != '0) check("pop_push_excl", 1, 0);
            end
        end
    end

    function automatic logic [7:0] rand_dst();
        int r;
        r = $urandom_range(0, 7);
        if (r < 4)       return 8'(r);
        else if (r < 6)  return 8'hFF;
        else if (r == 6) return 8'h07;
        else             return 8'($urandom);
    endfunction

    initial begin : stim
        // Reset state.
        #1;
        check("rst_pop", 32'(pop), 0);
        check("rst_push", 32'(push), 0);
        check("rst_D_push", 32'(D_push), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        step();
        step();
        reset = 1'b1;

        // Random traffic with periodic long backpressure to force timeouts.
        for (int c = 0; c < 3000; c++) begin
            step();
            pndng = 4'($urandom);
            for (int i = 0; i < N; i++) D_pop[i] = {rand_dst(), 8'($urandom)};
            full = ((c % 300) < 40) ? 4'hF : 4'($urandom & $urandom);
        end
        pndng = '0;
        full  = '0;
        repeat (10) step();

        // Reset mid-ROUTE: device 1 to device 3 while 3 is full.
        pndng = 4'b0010;
        D_pop[1] = 16'h0311;
        full = 4'b1000;
        step();
        step();
        pndng = '0;
        step();
        step();
        check("mid_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("mr_pop", 32'(pop), 0);
        check("mr_push", 32'(push), 0);
        check("mr_D_push", 32'(D_push), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_drop", 32'(drop_cnt), 0);
        step();
        step();
        reset = 1'b1;
        full = '0;
        step();
        step();
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_drop", 32'(drop_cnt), 0);

        // Round-robin from ptr 0: grants 0,1,2,3,0, one pop every 3 cycles.
        for (int i = 0; i < N; i++) D_pop[i] = {8'((i + 1) % N), 8'(8'h10 + i)};
        pndng = 4'b1111;
        for (int k = 1; k <= 15; k++) begin
            step();
            check("rr_pop", 32'(pop), (k % 3 == 2) ? 32'(4'b0001 << ((k / 3) % 4)) : 0);
        end
        pndng = '0;
        repeat (4) step();

        // Unicast: device 1 -> device 2.
        pndng = 4'b0010;
        D_pop[1] = 16'h02AB;
        step();
        check("uc_busy", 32'(busy), 1);
        check("uc_pop0", 32'(pop), 0);
        step();
        check("uc_pop", 32'(pop), 32'h2);
        pndng = '0;
        step();
        check("uc_push", 32'(push), 32'h4);
        check("uc_D_push", 32'(D_push), 32'h02AB);
        check("uc_pop_clr", 32'(pop), 0);
        step();
        check("uc_push_clr", 32'(push), 0);
        check("uc_D_hold", 32'(D_push), 32'h02AB);

        // Broadcast from device 2, blocked by full[0] for three ROUTE cycles.
        pndng = 4'b0100;
        D_pop[2] = 16'hFF5A;
        full = 4'b0001;
        step();
        step();
        check("bc_pop", 32'(pop), 32'h4);
        pndng = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bc_blocked", 32'(push), 0);
        end
        full = '0;
        step();
        check("bc_push", 32'(push), 32'hB);
        check("bc_D_push", 32'(D_push), 32'hFF5A);
        step();
        check("bc_push_clr", 32'(push), 0);

        // Invalid ID drops immediately.
        pndng = 4'b0001;
        D_pop[0] = 16'h0700;
        step();
        step();
        pndng = '0;
        step();
        check("inv_drop", 32'(drop_cnt), 1);
        check("inv_push", 32'(push), 0);

        // Timeout: device 1 -> device 3 with full[3] held; drop on ROUTE cycle 17.
        pndng = 4'b0010;
        D_pop[1] = 16'h0311;
        full = 4'b1000;
        step();
        step();
        pndng = '0;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("to_wait_drop", 32'(drop_cnt), 1);
            check("to_wait_busy", 32'(busy), 1);
        end
        step();
        check("to_drop", 32'(drop_cnt), 2);
        check("to_busy", 32'(busy), 0);
        check("to_push", 32'(push), 0);
        full = '0;
        step();

        // Self-addressed packets from all devices until the counter saturates.
        for (int i = 0; i < N; i++) D_pop[i] = {8'(i), 8'h3C};
        pndng = 4'b1111;
        repeat (260 * 3) step();
        check("sat_drop", 32'(drop_cnt), 32'hFF);
        repeat (9) step();
        check("sat_hold", 32'(drop_cnt), 32'hFF);
        pndng = '0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_sched_rr.md
# bus_sched_rr

Round-robin scheduler that shares the broadcast bus among `drvrs` device FIFOs. It pops one packet at a time from a requesting device and decodes the 8-bit destination ID in the packet MSBs. It then pushes the packet to the destination FIFO, or to every other device when the ID is the broadcast value. It respects per-destination `full` backpressure, applies a wait timeout, and counts dropped packets. It sits between the device FIFOs and the bus datapath, replacing fixed-priority selection with fair, stall-aware sequencing.

## Interface
- `drvrs`, 4: number of devices on the bus (2..16).
- `pckg_sz`, 16: packet width in bits; must be at least 9.
- `brdcst_ind`, 8'hFF: destination ID meaning "all devices except the source".
- `max_wait`, 16: maximum cycles spent waiting on `full` before the packet is dropped (≥1).
- `cnt_w`, 8: width of `drop_cnt`.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pndng`  in  `drvrs`  bit i high means device i's FIFO is non-empty; `D_pop[i]` is valid (show-ahead).
- `D_pop`  in  `drvrs` x `pckg_sz`  head packet of each device FIFO.
- `full`  in  `drvrs`  bit i high means device i's input FIFO cannot accept a push this cycle.
- `pop`  out  `drvrs`  one-hot pop strobe to the granted source.
- `push`  out  `drvrs`  push strobes to destination FIFOs; more than one bit is high only on broadcast.
- `D_push`  out  `pckg_sz`  packet driven to all destination FIFOs, qualified by `push`.
- `busy`  out  1  high in every state except IDLE.
- `drop_cnt`  out  `cnt_w`  saturating count of dropped packets.

## Operation
- Packet ID field: `dst = pkt[pckg_sz-1 -: 8]`.
- Valid destinations:
  - unicast when `dst < drvrs` and `dst != src`;
  - broadcast when `dst == brdcst_ind`, targeting the mask of all devices minus `src`.
  - Any other ID, including self-address, is invalid.
- FSM states: IDLE, POP, ROUTE.
- IDLE:
  - If any `pndng` bit is set, select the first set bit searching from `ptr` upward with wrap-around.
  - Register the selection as `src` and go to POP.
  - If no bit is set, stay in IDLE.
- POP:
  - If `pndng[src]` is still high: assert `pop[src]` for this cycle, capture `D_pop[src]` into `pkt`, set `ptr = (src+1) mod drvrs`, clear `wait_cnt`, and go to ROUTE.
  - Otherwise return to IDLE with no pop; `ptr` is unchanged.
- ROUTE:
  - Invalid ID: increment `drop_cnt` and go to IDLE. No push is issued.
  - Unicast with `!full[dst]`: assert `push[dst]`, drive `D_push = pkt`, and go to IDLE.
  - Broadcast with `(full & mask) == 0`: assert `push = mask` in the same cycle. A broadcast is never split across cycles.
  - Destination blocked: increment `wait_cnt`. When `wait_cnt == max_wait`, drop the packet (`drop_cnt++`) and go to IDLE.
- `drop_cnt` saturates at all ones and never wraps.
- `D_push` holds its last value outside push cycles.
- `pop` and `push` are registered, Moore-style outputs. They are never high in the same cycle.

## Timing
- Reset values: `pop=0`, `push=0`, `D_push=0`, `busy=0`, `drop_cnt=0`. Internal: `ptr=0`, `src=0`, `wait_cnt=0`, state IDLE.
- Reset is asynchronous on assertion and released synchronously to `clk`.
- Reset mid-operation: a packet already popped but not yet pushed is lost silently, with no `drop_cnt` increment.
- Latency from `pndng` high in IDLE at edge N:
  - `pop` is high in cycle N+1;
  - `push` is high in cycle N+2 at the earliest.
- Peak throughput is one packet per 3 cycles.
- Each blocked cycle in ROUTE adds one cycle of latency.
- The timeout drop occurs on the cycle in which `wait_cnt` reaches `max_wait`, i.e. `max_wait`+1 cycles spent in ROUTE.
- Fairness: after device i is served, it has the lowest priority. Each requester waits at most `drvrs`-1 other grants.
- `pndng` changes during POP or ROUTE do not affect the current packet. Only IDLE samples requests, plus the re-check of `pndng[src]` in POP.
- `full` is sampled every ROUTE cycle. A push is issued in the same cycle `full` is observed low.

## Test plan
- Reset: assert `reset=0` mid-ROUTE -> all outputs read 0 immediately; after release, state is IDLE and `drop_cnt=0`.
- Unicast: device 1 pending with `16'h02AB`, no full -> `pop=4'b0010` at N+1; `push=4'b0100` and `D_push=16'h02AB` at N+2.
- Round-robin: all 4 devices pending continuously -> grant order 0,1,2,3,0, one `pop` every 3 cycles.
- Broadcast: device 2 sends `16'hFF5A` with `full=4'b0001` for 3 cycles -> no push while blocked; then `push=4'b1011`, `D_push=16'hFF5A` in a single cycle.
- Drops: ID `8'h07` (invalid) -> `drop_cnt` goes 0→1. Unicast to device 3 with `full[3]` held high -> drop after 17 ROUTE cycles, `drop_cnt` goes 1→2, no push.
- Saturation and self-address: with `cnt_w=2`, drop 5 self-addressed packets (`dst == src`) -> no pushes; `drop_cnt` ends at 3.
